p251_mul_arb: RTL

P251_MUL_ARB -- requirements
Module: p251_mul_arb

---
 rtl/p251_mul_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/p251_mul_arb.sv
// ---------------------------------------------------------------------------
// p251_mul_arb
//   Two-requester front end for a single shared p251_mul engine. Requests are
//   arbitrated round-robin, the winner's operands are issued to the engine one
//   cycle later, and the winner's id is queued in a tag FIFO. Results come
//   back from the engine in issue order. Each result is steered to the
//   requester at the FIFO head as a one-cycle response pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[1:0]      per-requester request
//   req_in_1/2[15:0]    operands, byte i belongs to requester i
//   req_ready[1:0]      per-requester accept (combinational, one-hot or zero)
//   resp_valid[1:0]     one-cycle result pulse to requester i
//   resp_out[7:0]       result byte accompanying resp_valid
//   mul_start           issue strobe to p251_mul
//   mul_in_1/2[7:0]     operands to p251_mul
//   mul_out[7:0]        p251_mul result
//   mul_done            p251_mul result strobe (in issue order)
//   err                 sticky flag: result strobe seen with no op in flight
// ---------------------------------------------------------------------------
module p251_mul_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_in_1,
    input  logic [15:0] req_in_2,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic [7:0]  resp_out,
    output logic        mul_start,
    output logic [7:0]  mul_in_1,
    output logic [7:0]  mul_in_2,
    input  logic [7:0]  mul_out,
    input  logic        mul_done,
    output logic        err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic          tag_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          last_grant;

    logic [1:0]    grant;
    logic          accept;
    logic          acc_id;
    logic          pop;
    logic          head_id;

    // Round-robin: with both valid, the one that did not win last time goes.
    // NOTE: every combinational output gets a default first so no latch is
    // inferred for the unlisted cases.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Uses the registered count, so a pop this cycle only frees a slot for
    // the next cycle. Forced low while reset is held.
    assign req_ready = (rst_n && (count < CW'(DEPTH))) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign acc_id    = req_ready[1];
    assign pop       = mul_done && (count != '0);
    assign head_id   = tag_mem[rd_ptr];

    // NOTE: the tag storage has no reset; only pointers and count define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= acc_id;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
            mul_start  <= 1'b0;
            mul_in_1   <= '0;
            mul_in_2   <= '0;
            resp_valid <= 2'b00;
            resp_out   <= '0;
            err        <= 1'b0;
        end else begin
            mul_start <= accept;
            if (accept) begin
                last_grant <= acc_id;
                wr_ptr     <= wr_ptr + 1'b1;
                mul_in_1   <= acc_id ? req_in_1[15:8] : req_in_1[7:0];
                mul_in_2   <= acc_id ? req_in_2[15:8] : req_in_2[7:0];
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            resp_valid <= pop ? (head_id ? 2'b10 : 2'b01) : 2'b00;
            if (pop) begin
                resp_out <= mul_out;
            end

            // A result strobe with nothing in flight is a protocol error.
            if (mul_done && (count == '0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
